// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arbiter
// Function : N-channel valid/ready mux with a round-robin or fixed-priority
//            arbiter feeding a one-entry registered output stage.
// Revision : 1.0
// ============================================================================
module rr_mux_arbiter #(
    parameter int w  = 8,
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*w-1:0]  d,
    input  logic [N-1:0]    d_valid,
    output logic [N-1:0]    d_ready,
    input  logic            mode,
    output logic [w-1:0]    F,
    output logic [SW-1:0]   F_sel,
    output logic            F_valid,
    input  logic            F_ready
);

    logic [w-1:0]  r_f;
    logic [SW-1:0] r_f_sel;
    logic          r_f_valid;
    logic [SW-1:0] r_ptr;

    logic [SW-1:0] w_grant;
    logic [SW-1:0] w_idx;
    logic          w_found;
    logic          w_any;
    logic          w_load;
    logic          w_xfer;

    assign w_any  = |d_valid;
    assign w_load = ~r_f_valid | F_ready;
    assign w_xfer = w_load & w_any & ~rst;

    // The cyclic search wraps at N so indices >= N are never reachable.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        if (mode) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (d_valid[SW'(i)]) begin
                    w_grant = SW'(i);
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                w_idx = SW'((int'(r_ptr) + k) % N);
                if (!w_found && d_valid[w_idx]) begin
                    w_grant = w_idx;
                    w_found = 1'b1;
                end
            end
        end
    end

    assign d_ready = w_xfer ? (N'(1'b1) << w_grant) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_f       <= '0;
            r_f_sel   <= '0;
            r_f_valid <= 1'b0;
            r_ptr     <= SW'(N - 1);
        end else if (w_xfer) begin
            r_f       <= d[int'(w_grant)*w +: w];
            r_f_sel   <= w_grant;
            r_f_valid <= 1'b1;
            r_ptr     <= w_grant;
        end else if (r_f_valid && F_ready) begin
            r_f_valid <= 1'b0;
        end
    end

    assign F       = r_f;
    assign F_sel   = r_f_sel;
    assign F_valid = r_f_valid;

endmodule
`default_nettype wire
